wb_arbiter_2m: RTL and testbench
================================

# wb_arbiter_2m

Two-master, one-slave Wishbone arbiter that shares the single external bus between the instruction-side and data-side Wishbone bus interfaces of the CPU. It grants one master at a time and holds each grant for a whole `cyc` cycle. Arbitration is fixed-priority or round-robin. A watchdog aborts transfers the slave never acknowledges. It sits between the two bus interface instances and the SoC interconnect or memory.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `ARB_MODE`, 0, arbitration mode. 0 = fixed priority with m0 highest; 1 = round-robin.
- `TIMEOUT`, 255, number of stalled cycles allowed before abort. Legal range 1..65535. The counter is 16 bits wide.

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 (data side) controls.
- `m0_sel_i` in 4, `m0_addr_i` in ADDR_W, `m0_data_i` in DATA_W: master 0 request.
- `m0_data_o` out DATA_W: read data to master 0.
- `m0_ack_o`, `m0_err_o` out 1 each: master 0 response.
- `m1_*`: same set for master 1 (instruction side).
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: slave-side controls.
- `s_sel_o` out 4, `s_addr_o` out ADDR_W, `s_data_o` out DATA_W: slave-side request.
- `s_data_i` in DATA_W, `s_ack_i` in 1: slave response.

## Operation
- States:
  - IDLE: no master granted.
  - GNT0: master 0 granted.
  - GNT1: master 1 granted.
  - ABORT: one-cycle recovery after a watchdog abort.
- IDLE transitions:
  - Any `mX_cyc_i` high → GNTx on the next edge.
  - Both high with ARB_MODE=0 → GNT0.
  - Both high with ARB_MODE=1 → the master not in `last_gnt`.
- GNTx behaviour:
  - The slave outputs are a combinational mux of master x's signals.
  - `s_ack_i` and `s_data_i` are routed to master x only.
  - The other master sees ack=0, err=0 and data=0.
  - The grant is held while `mX_cyc_i` is high, including across back-to-back `stb` beats.
- GNTx exit when `mX_cyc_i` drops:
  - Other master's cyc high → GNTy directly, with no idle cycle.
  - Otherwise → IDLE.
  - `last_gnt` is updated to x.
- Watchdog: the counter increments each cycle in GNTx with `mX_stb_i`=1 and `s_ack_i`=0. It clears on ack, on state change, or when stb is low.
- Abort: when the counter reaches TIMEOUT with no ack that cycle, the arbiter:
  - asserts `mX_err_o`=1 combinationally in that same cycle;
  - moves to ABORT on the next edge.
- ABORT: `s_cyc_o` and `s_stb_o` are forced to 0 for one cycle, then the state returns to IDLE. Any pending request is re-arbitrated from IDLE.
- In IDLE and ABORT, all slave outputs are 0.
- Reset values:
  - state IDLE, counter 0, `last_gnt`=1 (so m0 wins the first round-robin tie);
  - all `s_*` outputs 0, and all `mX_ack_o`, `mX_err_o`, `mX_data_o` 0.

## Timing
- Grant latency is 1 cycle: master cyc seen high at edge N → slave `cyc`/`stb` visible after edge N.
- Ack and read data pass combinationally from slave to master in the same cycle, with zero added latency.
- Handover: master x drops cyc in cycle N while master y is requesting → y's request is on the slave bus in cycle N+1.
- Simultaneous ack and timeout in the same cycle: ack wins, no err, counter clears.
- Master drops cyc mid-wait (without ack): treated as a normal release with no err. The counter clears.
- Reset asserted mid-transfer: all outputs go to 0 asynchronously and the state goes to IDLE. No ack or err is generated.
- An err pulse lasts exactly 1 cycle. A master that keeps cyc high after err is re-granted through IDLE, so its retry costs 2 cycles.

## Structure
- Add to `define.v`:
  - state codes `ARB_IDLE`, `ARB_GNT0`, `ARB_GNT1`, `ARB_ABORT` (2 bits);
  - `RstN_Enable` 1'b0;
  - `ARB_FIXED` 0 and `ARB_RR` 1.
- One sub-module, `wb_arb_watchdog`:
  - ports: clk, rst, count_en, clear, TIMEOUT parameter, `expire` output;
  - a 16-bit saturating counter with `expire = (cnt == TIMEOUT)`.
- The top level holds the FSM, the `last_gnt` flop and the combinational muxes.

## Test plan
- Single read: m0 cyc/stb, addr 0x0000_1000; slave acks in 3rd cycle with 0xDEAD_BEEF → `m0_data_o`=0xDEAD_BEEF with ack in that cycle; m1 sees ack=0; state returns to IDLE.
- Fixed-priority contention: ARB_MODE=0, m0 and m1 request the same cycle, each with 4 single-beat transfers → m0 is served entirely first, then m1 with no idle cycle between them.
- Round-robin: ARB_MODE=1, both masters request continuously, each dropping cyc after one ack → grants alternate m0, m1, m0, m1.
- Timeout: TIMEOUT=8, m1 write to 0x0000_2000 and the slave never acks → `m1_err_o`=1 exactly on the 8th stalled cycle, `s_cyc_o`=0 the next cycle, then IDLE.
- Ack coinciding with expiry: TIMEOUT=4, ack on the 4th stalled cycle → ack delivered and no err.
- Reset mid-transfer: drop `rst` while in GNT0 → all `s_*` outputs are 0 immediately; after release, state is IDLE with counter 0, and a new m1 request is granted after 1 cycle.

Source files
------------

// File: rtl/wb_arbiter_2m_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
package wb_arbiter_2m_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT0  = 2'b01,
        ARB_GNT1  = 2'b10,
        ARB_ABORT = 2'b11
    } arb_state_t;

    localparam logic RstN_Enable = 1'b0;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    localparam int unsigned WDOG_W = 16;

    // Grant chosen from IDLE when both masters request in the same cycle.
    // last_gnt = 0 means m0 was served last, so round-robin hands over to m1.
    function automatic arb_state_t tie_winner(input int unsigned mode, input logic last_gnt);
        if (mode == ARB_FIXED) begin
            return ARB_GNT0;
        end
        return last_gnt ? ARB_GNT0 : ARB_GNT1;
    endfunction

endpackage

// File: rtl/wb_arbiter_2m_watchdog.sv
// Stall watchdog: counts cycles a granted strobe waits for an ack.
module wb_arb_watchdog
    import wb_arbiter_2m_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expire
);

    localparam logic [WDOG_W:0] LIMIT = (WDOG_W + 1)'(TIMEOUT);
    localparam logic [WDOG_W:0] ONE   = (WDOG_W + 1)'(1);

    logic [WDOG_W-1:0] cnt;

    // Saturating stall counter; clear has priority over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstN_Enable) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the stalled cycles already elapsed, so the current stalled
    // cycle is cnt+1; expiry fires on the TIMEOUT-th stalled cycle itself.
    always_comb begin
        expire = count_en && (({1'b0, cnt} + ONE) == LIMIT);
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with stall watchdog.
module wb_arbiter_2m
    import wb_arbiter_2m_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i
);

    arb_state_t state;
    logic       last_gnt;
    logic       count_en;
    logic       wdog_clear;
    logic       expire;

    // Watchdog runs only while the granted master strobes without an ack.
    always_comb begin
        count_en = ((state == ARB_GNT0) && m0_cyc_i && m0_stb_i && !s_ack_i) ||
                   ((state == ARB_GNT1) && m1_cyc_i && m1_stb_i && !s_ack_i);
        wdog_clear = !count_en || expire;
    end

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .count_en (count_en),
        .clear    (wdog_clear),
        .expire   (expire)
    );

    // Grant FSM and last-served tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstN_Enable) begin
            state    <= ARB_IDLE;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        state <= tie_winner(ARB_MODE, last_gnt);
                    end else if (m0_cyc_i) begin
                        state <= ARB_GNT0;
                    end else if (m1_cyc_i) begin
                        state <= ARB_GNT1;
                    end
                end
                ARB_GNT0: begin
                    // An aborted master also counts as served for fairness.
                    if (expire) begin
                        state    <= ARB_ABORT;
                        last_gnt <= 1'b0;
                    end else if (!m0_cyc_i) begin
                        state    <= m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
                        last_gnt <= 1'b0;
                    end
                end
                ARB_GNT1: begin
                    if (expire) begin
                        state    <= ARB_ABORT;
                        last_gnt <= 1'b1;
                    end else if (!m1_cyc_i) begin
                        state    <= m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
                        last_gnt <= 1'b1;
                    end
                end
                ARB_ABORT: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Bus mux: granted master drives the slave and alone sees its response.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m0_data_o = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        case (state)
            ARB_GNT0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                m0_data_o = s_data_i;
                m0_ack_o  = s_ack_i;
                m0_err_o  = expire;
            end
            ARB_GNT1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                m1_data_o = s_data_i;
                m1_ack_o  = s_ack_i;
                m1_err_o  = expire;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: one fixed-priority instance (TIMEOUT 8)
// and one round-robin instance (TIMEOUT 4) sharing the same stimulus.
module tb_wb_arbiter_2m;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        c0, s0, w0, c1, s1, w1, sack;
    logic [3:0]  sel0, sel1;
    logic [31:0] a0, d0, a1, d1, sdat;

    logic [31:0] a_m0_d, a_m1_d, a_s_addr, a_s_data;
    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we;
    logic [3:0]  a_s_sel;
    logic [31:0] b_m0_d, b_m1_d, b_s_addr, b_s_data;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we;
    logic [3:0]  b_s_sel;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst),
        .m0_cyc_i(c0), .m0_stb_i(s0), .m0_we_i(w0), .m0_sel_i(sel0), .m0_addr_i(a0), .m0_data_i(d0),
        .m0_data_o(a_m0_d), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m1_cyc_i(c1), .m1_stb_i(s1), .m1_we_i(w1), .m1_sel_i(sel1), .m1_addr_i(a1), .m1_data_i(d1),
        .m1_data_o(a_m1_d), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_sel_o(a_s_sel),
        .s_addr_o(a_s_addr), .s_data_o(a_s_data), .s_data_i(sdat), .s_ack_i(sack)
    );

    wb_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst),
        .m0_cyc_i(c0), .m0_stb_i(s0), .m0_we_i(w0), .m0_sel_i(sel0), .m0_addr_i(a0), .m0_data_i(d0),
        .m0_data_o(b_m0_d), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_cyc_i(c1), .m1_stb_i(s1), .m1_we_i(w1), .m1_sel_i(sel1), .m1_addr_i(a1), .m1_data_i(d1),
        .m1_data_o(b_m1_d), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_sel_o(b_s_sel),
        .s_addr_o(b_s_addr), .s_data_o(b_s_data), .s_data_i(sdat), .s_ack_i(sack)
    );

    typedef struct {
        logic        c0, s0, w0;
        logic [31:0] a0;
        logic        c1, s1, w1;
        logic [31:0] a1;
        logic        ack;
        logic [31:0] rd;
        int          gnt;   // 0: nobody on the bus, 1: m0, 2: m1
        logic        e0, e1;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic ic0, input logic is0, input logic iw0, input logic [31:0] ia0,
                                input logic ic1, input logic is1, input logic iw1, input logic [31:0] ia1,
                                input logic iack, input logic [31:0] ird, input int g,
                                input logic ie0, input logic ie1);
        vec_t v;
        v.c0 = ic0; v.s0 = is0; v.w0 = iw0; v.a0 = ia0;
        v.c1 = ic1; v.s1 = is1; v.w1 = iw1; v.a1 = ia1;
        v.ack = iack; v.rd = ird; v.gnt = g; v.e0 = ie0; v.e1 = ie1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", tag, act, exp);
        end
    endtask

    // Expected bus state follows from the hand-assigned grant owner.
    task automatic check(input logic which, input int gnt, input logic e0, input logic e1, input string tag);
        logic [127:0] xs, x0, x1, as, am0, am1;
        xs = '0;
        x0 = 128'({1'b0, e0, 32'h0});
        x1 = 128'({1'b0, e1, 32'h0});
        if (gnt == 1) begin
            xs = 128'({c0, s0, w0, sel0, a0, d0});
            x0 = 128'({sack, e0, sdat});
        end else if (gnt == 2) begin
            xs = 128'({c1, s1, w1, sel1, a1, d1});
            x1 = 128'({sack, e1, sdat});
        end
        if (which) begin
            as  = 128'({b_s_cyc, b_s_stb, b_s_we, b_s_sel, b_s_addr, b_s_data});
            am0 = 128'({b_m0_ack, b_m0_err, b_m0_d});
            am1 = 128'({b_m1_ack, b_m1_err, b_m1_d});
        end else begin
            as  = 128'({a_s_cyc, a_s_stb, a_s_we, a_s_sel, a_s_addr, a_s_data});
            am0 = 128'({a_m0_ack, a_m0_err, a_m0_d});
            am1 = 128'({a_m1_ack, a_m1_err, a_m1_d});
        end
        chk({tag, "/slave"}, as, xs);
        chk({tag, "/m0"}, am0, x0);
        chk({tag, "/m1"}, am1, x1);
    endtask

    task automatic step(input logic ic0, input logic is0, input logic iw0, input logic [31:0] ia0,
                        input logic ic1, input logic is1, input logic iw1, input logic [31:0] ia1,
                        input logic iack, input logic [31:0] ird);
        @(posedge clk);
        #1;
        c0 = ic0; s0 = is0; w0 = iw0; a0 = ia0; d0 = ia0 ^ 32'h5555_0000;
        c1 = ic1; s1 = is1; w1 = iw1; a1 = ia1; d1 = ia1 ^ 32'hAAAA_0000;
        sack = iack; sdat = ird;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        c0 = L; s0 = L; w0 = L; a0 = '0; d0 = '0;
        c1 = L; s1 = L; w1 = L; a1 = '0; d1 = '0;
        sack = L; sdat = '0;
    endtask

    // Reset both instances with a busy bus on the inputs; outputs must stay 0.
    task automatic do_reset();
        rst = 1'b0;
        c0 = H; s0 = H; c1 = H; s1 = H; sack = H; sdat = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(1'b0, 0, L, L, "reset_a");
        check(1'b1, 0, L, L, "reset_b");
        idle_inputs();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: actual=expired required=finished");
        $fatal(1);
    end

    initial begin
        sel0 = 4'hF;
        sel1 = 4'h3;
        idle_inputs();

        // Single read, then fixed-priority contention (4 beats each).
        tbl[0]  = mk(H,H,L,32'h1000, L,L,L,32'h0,   L,32'h0,         0, L,L);
        tbl[1]  = mk(H,H,L,32'h1000, L,L,L,32'h0,   L,32'h0,         1, L,L);
        tbl[2]  = mk(H,H,L,32'h1000, L,L,L,32'h0,   L,32'h0,         1, L,L);
        tbl[3]  = mk(H,H,L,32'h1000, L,L,L,32'h0,   H,32'hDEADBEEF,  1, L,L);
        tbl[4]  = mk(L,L,L,32'h0,    L,L,L,32'h0,   L,32'h0,         1, L,L);
        tbl[5]  = mk(L,L,L,32'h0,    L,L,L,32'h0,   L,32'h0,         0, L,L);
        tbl[6]  = mk(H,H,L,32'h100,  H,H,H,32'h200, L,32'h0,         0, L,L);
        tbl[7]  = mk(H,H,L,32'h100,  H,H,H,32'h200, H,32'h11,        1, L,L);
        tbl[8]  = mk(H,H,L,32'h104,  H,H,H,32'h200, H,32'h22,        1, L,L);
        tbl[9]  = mk(H,H,L,32'h108,  H,H,H,32'h200, H,32'h33,        1, L,L);
        tbl[10] = mk(H,H,L,32'h10C,  H,H,H,32'h200, H,32'h44,        1, L,L);
        tbl[11] = mk(L,L,L,32'h0,    H,H,H,32'h200, L,32'h0,         1, L,L);
        tbl[12] = mk(L,L,L,32'h0,    H,H,H,32'h200, H,32'h55,        2, L,L);
        tbl[13] = mk(L,L,L,32'h0,    H,H,H,32'h204, H,32'h66,        2, L,L);
        tbl[14] = mk(L,L,L,32'h0,    H,H,H,32'h208, H,32'h77,        2, L,L);
        tbl[15] = mk(L,L,L,32'h0,    H,H,H,32'h20C, H,32'h88,        2, L,L);
        tbl[16] = mk(L,L,L,32'h0,    L,L,L,32'h0,   L,32'h0,         2, L,L);
        tbl[17] = mk(L,L,L,32'h0,    L,L,L,32'h0,   L,32'h0,         0, L,L);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].c0, tbl[i].s0, tbl[i].w0, tbl[i].a0,
                 tbl[i].c1, tbl[i].s1, tbl[i].w1, tbl[i].a1, tbl[i].ack, tbl[i].rd);
            check(1'b0, tbl[i].gnt, tbl[i].e0, tbl[i].e1, $sformatf("vec%0d", i));
        end

        // Timeout (TIMEOUT 8): m1 write never acked, err on 8th stalled cycle,
        // ABORT, IDLE, then re-grant while m1 keeps cyc high.
        do_reset();
        step(L,L,L,32'h0, H,H,H,32'h2000, L,32'h0);
        check(1'b0, 0, L, L, "to_req");
        for (int k = 1; k <= 8; k++) begin
            step(L,L,L,32'h0, H,H,H,32'h2000, L,32'h0);
            check(1'b0, 2, L, (k == 8), $sformatf("to_stall%0d", k));
        end
        step(L,L,L,32'h0, H,H,H,32'h2000, L,32'h0);
        check(1'b0, 0, L, L, "to_abort");
        step(L,L,L,32'h0, H,H,H,32'h2000, L,32'h0);
        check(1'b0, 0, L, L, "to_idle");
        step(L,L,L,32'h0, H,H,H,32'h2000, L,32'h0);
        check(1'b0, 2, L, L, "to_regrant");

        // Ack on the 4th waiting cycle (TIMEOUT 4): ack wins, counter restarts.
        do_reset();
        step(H,H,L,32'h3000, L,L,L,32'h0, L,32'h0);
        check(1'b1, 0, L, L, "ae_req");
        for (int k = 1; k <= 3; k++) begin
            step(H,H,L,32'h3000, L,L,L,32'h0, L,32'h0);
            check(1'b1, 1, L, L, $sformatf("ae_stall%0d", k));
        end
        step(H,H,L,32'h3000, L,L,L,32'h0, H,32'hCAFEF00D);
        check(1'b1, 1, L, L, "ae_ack");
        for (int k = 1; k <= 4; k++) begin
            step(H,H,L,32'h3004, L,L,L,32'h0, L,32'h0);
            check(1'b1, 1, (k == 4), L, $sformatf("ae_restall%0d", k));
        end
        step(H,H,L,32'h3004, L,L,L,32'h0, L,32'h0);
        check(1'b1, 0, L, L, "ae_abort");

        // Round-robin: alternating grants, then an IDLE tie after m0 was last.
        do_reset();
        step(H,H,L,32'h400, H,H,L,32'h500, L,32'h0);
        check(1'b1, 0, L, L, "rr_u0");
        step(H,H,L,32'h400, H,H,L,32'h500, H,32'h1);
        check(1'b1, 1, L, L, "rr_u1");
        step(L,L,L,32'h0,   H,H,L,32'h500, L,32'h0);
        check(1'b1, 1, L, L, "rr_u2");
        step(H,H,L,32'h404, H,H,L,32'h500, H,32'h2);
        check(1'b1, 2, L, L, "rr_u3");
        step(H,H,L,32'h404, L,L,L,32'h0,   L,32'h0);
        check(1'b1, 2, L, L, "rr_u4");
        step(H,H,L,32'h404, H,H,L,32'h504, H,32'h3);
        check(1'b1, 1, L, L, "rr_u5");
        step(L,L,L,32'h0,   L,L,L,32'h0,   L,32'h0);
        check(1'b1, 1, L, L, "rr_u6");
        step(H,H,L,32'h408, H,H,L,32'h508, L,32'h0);
        check(1'b1, 0, L, L, "rr_u7");
        step(H,H,L,32'h408, H,H,L,32'h508, L,32'h0);
        check(1'b1, 2, L, L, "rr_u8");

        // Reset asserted mid-transfer, between clock edges.
        do_reset();
        step(H,H,L,32'h6000, L,L,L,32'h0, L,32'h0);
        check(1'b0, 0, L, L, "rm_req");
        step(H,H,L,32'h6000, L,L,L,32'h0, H,32'h1234_5678);
        check(1'b0, 1, L, L, "rm_gnt");
        #2;
        rst = 1'b0;
        #1;
        check(1'b0, 0, L, L, "rm_async_a");
        check(1'b1, 0, L, L, "rm_async_b");
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        step(L,L,L,32'h0, H,H,L,32'h7000, L,32'h0);
        check(1'b0, 0, L, L, "rm_idle");
        for (int k = 1; k <= 8; k++) begin
            step(L,L,L,32'h0, H,H,L,32'h7000, L,32'h0);
            check(1'b0, 2, L, (k == 8), $sformatf("rm_m1_%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
